// File: rtl/float_pkg.sv
// Shared types and constants for the float operand feeder: FSM states and
// IEEE-754 single-precision field layout.
package float_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StHold  = 2'd2
  } feed_state_e;

  localparam logic [7:0] FP_EXP_MAX  = 8'hFF;
  localparam logic [7:0] FP_EXP_ZERO = 8'h00;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float32_t;

  // Zero/denormal or inf/NaN exponent: the adder takes its slow path for these.
  function automatic logic is_special(input logic [31:0] word);
    float32_t f;
    f = float32_t'(word);
    return (f.exp == FP_EXP_MAX) || (f.exp == FP_EXP_ZERO);
  endfunction

endpackage

// File: rtl/operand_fifo.sv
// Parameterised synchronous FIFO holding packed {a, b} operand pairs.
// Pushes while full and pops while empty are ignored.
module operand_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 64,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned LvlW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [LvlW-1:0]  level_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q;
  logic             push_en, pop_en;

  assign push_en = push_i && (level_q < LvlW'(Depth));
  assign pop_en  = pop_i && (level_q != '0);

  // Storage carries no reset; validity is tracked by level_q alone.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push_en, pop_en})
        2'b10:   level_q <= level_q + LvlW'(1);
        2'b01:   level_q <= level_q - LvlW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/float_operand_feeder.sv
// Buffers IEEE-754 operand pairs and issues them to the adder one at a time,
// pacing issue as ISSUE -> HOLD -> IDLE so the adder stage status can settle.
module float_operand_feeder
  import float_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     s_valid_i,
  input  logic [31:0]              s_a_i,
  input  logic [31:0]              s_b_i,
  output logic                     s_ready_o,
  input  logic                     stage0_free_i,
  output logic                     inp_rdy_o,
  output logic [31:0]              op_a_o,
  output logic [31:0]              op_b_o,
  output logic                     special_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [15:0]              issued_cnt_o
);

  localparam int unsigned LvlW = $clog2(DEPTH) + 1;

  feed_state_e     state_q;
  logic            inp_rdy_q;
  logic [31:0]     op_a_q, op_b_q;
  logic [15:0]     issued_q;
  logic [63:0]     head;
  logic [LvlW-1:0] level;
  logic            push, pop;

  assign s_ready_o = level < LvlW'(DEPTH);
  assign push      = s_valid_i && s_ready_o;
  assign pop       = (state_q == StIssue);

  operand_fifo #(
    .Depth (DEPTH),
    .Width (64)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i ({s_a_i, s_b_i}),
    .pop_i   (pop),
    .rdata_o (head),
    .level_o (level)
  );

  // Operands are latched on entry to ISSUE; the head cannot move until the
  // pop at the end of ISSUE, so the outputs match the head throughout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      inp_rdy_q <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      issued_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if ((level != '0) && stage0_free_i) begin
            state_q   <= StIssue;
            inp_rdy_q <= 1'b1;
            op_a_q    <= head[63:32];
            op_b_q    <= head[31:0];
          end
        end
        StIssue: begin
          state_q   <= StHold;
          inp_rdy_q <= 1'b0;
          issued_q  <= issued_q + 16'd1;
        end
        StHold: begin
          state_q <= StIdle;
        end
        default: begin
          state_q   <= StIdle;
          inp_rdy_q <= 1'b0;
        end
      endcase
    end
  end

  assign inp_rdy_o    = inp_rdy_q;
  assign op_a_o       = op_a_q;
  assign op_b_o       = op_b_q;
  assign special_o    = inp_rdy_q && (is_special(op_a_q) || is_special(op_b_q));
  assign level_o      = level;
  assign issued_cnt_o = issued_q;

endmodule

// File: tb/tb_float_operand_feeder.sv
// Self-checking bench for float_operand_feeder: directed vector table, directed
// corner sequences and randomized traffic against a queue-based reference model.
module tb_float_operand_feeder;

  localparam int unsigned DEPTH = 4;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          s_valid_i;
  logic [31:0]   s_a_i, s_b_i;
  logic          s_ready_o;
  logic          stage0_free_i;
  logic          inp_rdy_o;
  logic [31:0]   op_a_o, op_b_o;
  logic          special_o;
  logic [LW-1:0] level_o;
  logic [15:0]   issued_cnt_o;

  float_operand_feeder #(.DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .s_valid_i     (s_valid_i),
    .s_a_i         (s_a_i),
    .s_b_i         (s_b_i),
    .s_ready_o     (s_ready_o),
    .stage0_free_i (stage0_free_i),
    .inp_rdy_o     (inp_rdy_o),
    .op_a_o        (op_a_o),
    .op_b_o        (op_b_o),
    .special_o     (special_o),
    .level_o       (level_o),
    .issued_cnt_o  (issued_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: a queue of pairs plus the rule that an issue may start on
  // an edge only if the queue was non-empty, the adder was free, no pair is
  // currently presented and at least 3 edges have passed since the last start.
  logic [63:0] mq[$];
  bit          m_rdy;
  logic [31:0] m_a, m_b;
  logic [15:0] m_iss;
  int          edge_n, next_ok;

  function automatic bit fp_special(input logic [31:0] x);
    return (x[30:23] == 8'hFF) || (x[30:23] == 8'h00);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rdy = 0; m_a = '0; m_b = '0; m_iss = '0;
    edge_n = 0; next_ok = 0;
  endtask

  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b, input bit free);
    bit acc, start;
    logic [63:0] hd;
    s_valid_i = v; s_a_i = a; s_b_i = b; stage0_free_i = free;
    acc   = v && (mq.size() < DEPTH);
    start = !m_rdy && (edge_n >= next_ok) && (mq.size() > 0) && free;
    if (m_rdy) begin
      void'(mq.pop_front());
      m_iss++;
    end
    if (start) begin
      hd = mq[0];
      m_a = hd[63:32]; m_b = hd[31:0];
      next_ok = edge_n + 3;
    end
    if (acc) mq.push_back({a, b});
    m_rdy = start;
    @(posedge clk_i); #1;
    edge_n++;
    chk("m_s_ready", 32'(s_ready_o), 32'(mq.size() < DEPTH));
    chk("m_inp_rdy", 32'(inp_rdy_o), 32'(m_rdy));
    chk("m_op_a", op_a_o, m_a);
    chk("m_op_b", op_b_o, m_b);
    chk("m_special", 32'(special_o), 32'(m_rdy && (fp_special(m_a) || fp_special(m_b))));
    chk("m_level", 32'(level_o), 32'(mq.size()));
    chk("m_issued", 32'(issued_cnt_o), 32'(m_iss));
  endtask

  task automatic do_reset();
    s_valid_i = 0; stage0_free_i = 0;
    rst_ni = 0;
    @(posedge clk_i); #1;
    rst_ni = 1;
    model_reset();
  endtask

  typedef struct {
    bit          v;
    logic [31:0] a, b;
    bit          free;
    bit          e_rdy;
    logic [31:0] e_a, e_b;
    bit          e_sp;
    int          e_lvl, e_iss;
  } vec_t;

  vec_t tbl[9];

  logic [31:0] pa[$], pb[$], ga[$], gb[$];
  int          gt[$];
  int          idx;
  bit          was_ready, v;
  logic [31:0] ra, rb;

  initial begin
    // Single pair then special / non-special pair (expected values by hand).
    tbl[0] = '{1, 32'h3F800000, 32'h40000000, 1, 0, 32'h0,        32'h0,        0, 1, 0};
    tbl[1] = '{0, 32'h0,        32'h0,        1, 1, 32'h3F800000, 32'h40000000, 0, 1, 0};
    tbl[2] = '{0, 32'h0,        32'h0,        1, 0, 32'h3F800000, 32'h40000000, 0, 0, 1};
    tbl[3] = '{1, 32'h7F800000, 32'h00000000, 1, 0, 32'h3F800000, 32'h40000000, 0, 1, 1};
    tbl[4] = '{1, 32'h3F800000, 32'h3F800000, 1, 1, 32'h7F800000, 32'h00000000, 1, 2, 1};
    tbl[5] = '{0, 32'h0,        32'h0,        1, 0, 32'h7F800000, 32'h00000000, 0, 1, 2};
    tbl[6] = '{0, 32'h0,        32'h0,        1, 0, 32'h7F800000, 32'h00000000, 0, 1, 2};
    tbl[7] = '{0, 32'h0,        32'h0,        1, 1, 32'h3F800000, 32'h3F800000, 0, 1, 2};
    tbl[8] = '{0, 32'h0,        32'h0,        1, 0, 32'h3F800000, 32'h3F800000, 0, 0, 3};

    rst_ni = 0; s_valid_i = 0; s_a_i = '0; s_b_i = '0; stage0_free_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_s_ready", 32'(s_ready_o), 32'd1);
    chk("rst_inp_rdy", 32'(inp_rdy_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_issued", 32'(issued_cnt_o), 32'd0);
    chk("rst_op_a", op_a_o, 32'd0);
    rst_ni = 1;
    model_reset();

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].free);
      chk($sformatf("tbl%0d_inp_rdy", i), 32'(inp_rdy_o), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_op_a", i), op_a_o, tbl[i].e_a);
      chk($sformatf("tbl%0d_op_b", i), op_b_o, tbl[i].e_b);
      chk($sformatf("tbl%0d_special", i), 32'(special_o), 32'(tbl[i].e_sp));
      chk($sformatf("tbl%0d_level", i), 32'(level_o), 32'(tbl[i].e_lvl));
      chk($sformatf("tbl%0d_issued", i), 32'(issued_cnt_o), 32'(tbl[i].e_iss));
    end

    // Fill with adder busy: 4 accepted, 5th held by upstream, nothing issued.
    do_reset();
    pa.delete(); pb.delete();
    for (int k = 0; k < 5; k++) begin
      pa.push_back(32'h40000000 + 32'(k) * 32'h00100000);
      pb.push_back(32'h3F000000 + 32'(k));
    end
    idx = 0;
    for (int k = 0; k < 7; k++) begin
      was_ready = s_ready_o;
      step(1, pa[idx], pb[idx], 0);
      if (was_ready && idx < 4) idx++;
      chk("fill_no_issue", 32'(inp_rdy_o), 32'd0);
    end
    chk("fill_accepted", 32'(idx), 32'd4);
    chk("fill_level", 32'(level_o), 32'(DEPTH));
    chk("fill_s_ready", 32'(s_ready_o), 32'd0);

    // Drain: one issue every 3 cycles, in push order.
    ga.delete(); gb.delete(); gt.delete();
    for (int k = 0; k < 14; k++) begin
      step(0, 32'h0, 32'h0, 1);
      if (inp_rdy_o) begin
        ga.push_back(op_a_o); gb.push_back(op_b_o); gt.push_back(edge_n);
      end
    end
    chk("drain_count", 32'(ga.size()), 32'd4);
    for (int k = 0; k < 4 && k < ga.size(); k++) begin
      chk($sformatf("drain%0d_a", k), ga[k], pa[k]);
      chk($sformatf("drain%0d_b", k), gb[k], pb[k]);
      if (k > 0) chk($sformatf("drain%0d_gap", k), 32'(gt[k] - gt[k-1]), 32'd3);
    end
    chk("drain_level", 32'(level_o), 32'd0);
    chk("drain_issued", 32'(issued_cnt_o), 32'd4);

    // Reset asserted in the middle of an ISSUE cycle.
    do_reset();
    for (int k = 0; k < 4; k++) step(1, 32'h41000000 + 32'(k), 32'h42000000, 0);
    step(0, 32'h0, 32'h0, 1);
    chk("mid_issue_entered", 32'(inp_rdy_o), 32'd1);
    #2;
    rst_ni = 0;
    #1;
    chk("mid_rst_inp_rdy", 32'(inp_rdy_o), 32'd0);
    chk("mid_rst_level", 32'(level_o), 32'd0);
    chk("mid_rst_issued", 32'(issued_cnt_o), 32'd0);
    chk("mid_rst_s_ready", 32'(s_ready_o), 32'd1);
    chk("mid_rst_op_a", op_a_o, 32'd0);
    chk("mid_rst_special", 32'(special_o), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      step(0, 32'h0, 32'h0, 1);
      chk("post_rst_idle", 32'(inp_rdy_o), 32'd0);
    end
    step(1, 32'h3F800000, 32'h3F800000, 1);
    step(0, 32'h0, 32'h0, 1);
    chk("post_rst_new_issue", 32'(inp_rdy_o), 32'd1);

    // Pointer wrap: 2*DEPTH+1 pairs pushed and issued interleaved.
    do_reset();
    pa.delete(); pb.delete(); ga.delete(); gb.delete();
    for (int k = 0; k < 2 * DEPTH + 1; k++) begin
      pa.push_back($urandom); pb.push_back($urandom);
    end
    idx = 0;
    for (int k = 0; k < 100 && ga.size() < 2 * DEPTH + 1; k++) begin
      v = (idx < 2 * DEPTH + 1) && ($urandom_range(0, 3) != 0);
      was_ready = s_ready_o;
      if (v) step(1, pa[idx], pb[idx], 1);
      else step(0, 32'h0, 32'h0, 1);
      if (v && was_ready) idx++;
      if (inp_rdy_o) begin
        ga.push_back(op_a_o); gb.push_back(op_b_o);
      end
    end
    chk("wrap_issue_count", 32'(ga.size()), 32'(2 * DEPTH + 1));
    for (int k = 0; k < ga.size() && k < pa.size(); k++) begin
      chk($sformatf("wrap%0d_a", k), ga[k], pa[k]);
      chk($sformatf("wrap%0d_b", k), gb[k], pb[k]);
    end
    step(0, 32'h0, 32'h0, 1);
    chk("wrap_issued_cnt", 32'(issued_cnt_o), 32'd9);

    // Randomized traffic against the reference model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      if ($urandom_range(0, 3) == 0) rb[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      step($urandom_range(0, 1) != 0, ra, rb, $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
